mine_field_gen: RTL and testbench
=================================

// Module: mine_field_gen
// PURPOSE
//  Upstream stage of the game FSM. On a start pulse, places exactly MINE_COUNT mines on a
//  GRID_SIZE x GRID_SIZE board using a free-running LFSR, never on the player's safe cell,
//  then computes each cell's 4-bit neighbour count. Outputs bomb_grid and counts
//  (the game's initGrid/states), held stable while valid=1.
// PARAMETERS
//  GRID_SIZE   9   board edge; CELLS = GRID_SIZE*GRID_SIZE (max 128, 7-bit index)
//  MINE_COUNT  10  mines placed; elaboration error if > CELLS-1 (> CELLS-9 with safe zone)
// PORTS
//  clock      in   1         system clock
//  reset      in   1         synchronous, active-low
//  start      in   1         1-cycle request; sampled only in IDLE or DONE
//  safe_idx   in   7         row*GRID_SIZE+col of first click; captured on accepted start
//  seed_load  in   1         load seed into LFSR this cycle
//  seed       in   16        LFSR seed; 0 is replaced by 16'hACE1
//  busy       out  1         high in PLACE/COUNT
//  done       out  1         1-cycle pulse when field complete
//  valid      out  1         bomb_grid/counts valid; high from done until next accepted start
//  bomb_grid  out  CELLS     bit i = mine at cell i
//  counts     out  4*CELLS   nibble i = adjacent mines 0..8, or 4'hF if cell i is a mine
// BEHAVIOUR
//  - Reset: state IDLE, LFSR=16'hACE1, busy=0, done=0, valid=0, bomb_grid=0, counts=0, placed=0.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state
//    (button timing supplies entropy). seed_load overrides the advance that cycle, any
//    state; generation in progress continues from the new value.
//  - IDLE/DONE + start: capture safe_idx, clear bomb_grid/counts/placed, valid<=0, -> PLACE.
//    start while busy is ignored. safe_idx >= CELLS: no exclusion applied.
//  - PLACE: per cycle cand=lfsr[6:0]; set bomb_grid[cand], placed++ iff cand<CELLS,
//    bit not already set, cand not excluded. At most one placement per cycle.
//    When placed==MINE_COUNT -> COUNT same edge (MINE_COUNT=0 -> COUNT after 1 cycle).
//  - COUNT: idx 0..CELLS-1, one cell per cycle; sum the <=8 in-grid neighbours (row/col
//    edges clipped, no wrap); write 4'hF if cell is a mine. Exactly CELLS cycles.
//    After idx=CELLS-1 -> DONE with done=1 for that one cycle, valid=1.
//  - DONE: outputs frozen until accepted start or reset. Reset mid-PLACE/COUNT discards all.
//  - Widths: placed is 7-bit; neighbour sum 4-bit, never exceeds 8.
// CONFIGURATION
//  MINE_GEN_SAFE_ZONE_EN defined: exclusion = full 3x3 around safe_idx (clipped at edges),
//    so first click always reveals a 0 cell. Undefined: exclusion = safe_idx only.
// STRUCTURE
//  minesweeper_pkg: GRID_SIZE, CELLS, CNT_BOMB=4'hF, state enum {IDLE,PLACE,COUNT,DONE},
//    functions idx_row/idx_col/rc_idx, is_adjacent(a,b).
//  Sub-module mf_lfsr16 (clock, reset, load, seed, q[15:0]); rest is one FSM + counters.
// TESTING
//  1 Reset then idle 5 cycles -> busy=0, valid=0, bomb_grid=0, counts=0, LFSR=16'hACE1.
//  2 seed_load seed=0, start safe_idx=40 -> after done: popcount(bomb_grid)=10,
//    bit 40 clear; with SAFE_ZONE_EN bits 30,31,32,39,41,48,49,50 also clear, counts[40]=0.
//  3 Same seed, same start cycle twice -> identical bomb_grid; done exactly 1 cycle wide;
//    COUNT phase exactly 81 cycles (busy-to-done measured from first COUNT cycle).
//  4 Every generated field: each nibble equals reference-model neighbour sum, corner 0
//    sees only cells 1,9,10; mine cells read 4'hF; no column wrap (cell 8 vs 9).
//  5 start asserted repeatedly during PLACE/COUNT -> ignored, single done; start in DONE
//    -> valid drops next cycle, new field generated.
//  6 reset low mid-COUNT -> next cycle IDLE, all outputs zero; MINE_COUNT=0 build ->
//    bomb_grid=0, all counts 0, done after 1+81 cycles.

Source files
------------

// File: rtl/mine_field_gen_pkg.sv
// Shared definitions for the mine field generator: board geometry,
// state encoding and cell index helpers.
package mine_field_gen_pkg;

    localparam int          GRID_SIZE    = 9;
    localparam int          CELLS        = GRID_SIZE * GRID_SIZE;
    localparam logic [3:0]  CNT_BOMB     = 4'hF;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int idx_row(input int idx, input int g);
        return idx / g;
    endfunction

    function automatic int idx_col(input int idx, input int g);
        return idx % g;
    endfunction

    function automatic int rc_idx(input int r, input int c, input int g);
        return r * g + c;
    endfunction

    // True when b is one of the (up to) 8 cells touching a; a cell is not
    // adjacent to itself.
    function automatic logic is_adjacent(input int a, input int b, input int g);
        int dr;
        int dc;
        dr = idx_row(a, g) - idx_row(b, g);
        dc = idx_col(a, g) - idx_col(b, g);
        return (a != b) && (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
    endfunction

endpackage

// File: rtl/mine_field_gen_lfsr.sv
// mf_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
// A load replaces the step for that cycle; a zero seed would lock the
// register, so it is swapped for the default value.
module mf_lfsr16
    import mine_field_gen_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

    // Step every cycle, or take the seed when loading.
    always_ff @(posedge clock) begin
        if (!reset)
            r_q <= LFSR_DEFAULT;
        else if (i_load)
            r_q <= (i_seed == 16'h0000) ? LFSR_DEFAULT : i_seed;
        else
            r_q <= {r_q[14:0], w_fb};
    end

    assign o_q = r_q;

endmodule

// File: rtl/mine_field_gen.sv
// mine_field_gen: places MINE_COUNT mines on a GRID_SIZE x GRID_SIZE board
// from a free-running LFSR, avoiding the first-click cell, then walks the
// board one cell per cycle to produce neighbour counts.
// Optional macro MINE_GEN_SAFE_ZONE_EN widens the exclusion to the 3x3
// block around the first click so that cell always reads 0.
module mine_field_gen #(
    parameter int GRID_SIZE  = 9,
    parameter int MINE_COUNT = 10
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_start,
    input  logic [6:0]                       i_safe_idx,
    input  logic                             i_seed_load,
    input  logic [15:0]                      i_seed,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_valid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]   o_bomb_grid,
    output logic [4*GRID_SIZE*GRID_SIZE-1:0] o_counts
);

    import mine_field_gen_pkg::*;

    localparam int N = GRID_SIZE * GRID_SIZE;
`ifdef MINE_GEN_SAFE_ZONE_EN
    localparam int MAX_MINES = N - 9;
`else
    localparam int MAX_MINES = N - 1;
`endif
    localparam logic [6:0] MC7   = 7'(MINE_COUNT);
    localparam logic [6:0] LAST7 = 7'(N - 1);

    if (N > 128 || MINE_COUNT < 0 || MINE_COUNT > MAX_MINES) begin : g_bad_cfg
        $error("mine_field_gen: MINE_COUNT does not fit on the board");
    end

    state_t               r_state;
    state_t               w_next;
    logic [N-1:0]         r_bomb;
    logic [N-1:0][3:0]    r_counts;
    logic [6:0]           r_placed;
    logic [6:0]           r_idx;
    logic [6:0]           r_safe;
    logic                 r_done;
    logic                 r_valid;

    logic [15:0]          w_lfsr;
    logic [6:0]           w_cand;
    logic [127:0]         w_bomb_pad;
    logic                 w_excl;
    logic                 w_cand_ok;
    logic                 w_do_place;
    logic [6:0]           w_placed_nxt;
    logic                 w_accept;
    logic                 w_last_idx;
    logic [3:0]           w_nsum;
    logic                 w_lfsr_unused;

    mf_lfsr16 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .i_load (i_seed_load),
        .i_seed (i_seed),
        .o_q    (w_lfsr)
    );

    // Only the low 7 bits pick a cell; the rest just keeps the sequence long.
    assign w_cand        = w_lfsr[6:0];
    assign w_lfsr_unused = ^w_lfsr[15:7];
    assign w_bomb_pad    = 128'(r_bomb);

    // Decide whether the candidate cell falls inside the first-click exclusion.
    always_comb begin
        w_excl = 1'b0;
        if (int'(r_safe) < N) begin
`ifdef MINE_GEN_SAFE_ZONE_EN
            w_excl = (w_cand == r_safe) ||
                     is_adjacent(int'(w_cand), int'(r_safe), GRID_SIZE);
`else
            w_excl = (w_cand == r_safe);
`endif
        end
    end

    assign w_cand_ok    = (int'(w_cand) < N) && !w_bomb_pad[w_cand] && !w_excl;
    assign w_do_place   = w_cand_ok && (r_placed < MC7);
    assign w_placed_nxt = r_placed + 7'(w_do_place);

    // Neighbour sum of the cell under r_idx, clipped at every board edge.
    always_comb begin : p_nsum
        int row;
        int col;
        int nr;
        int nc;
        row    = idx_row(int'(r_idx), GRID_SIZE);
        col    = idx_col(int'(r_idx), GRID_SIZE);
        nr     = 0;
        nc     = 0;
        w_nsum = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = row + dr;
                nc = col + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < GRID_SIZE &&
                    nc >= 0 && nc < GRID_SIZE)
                    w_nsum = w_nsum + 4'(w_bomb_pad[7'(rc_idx(nr, nc, GRID_SIZE))]);
            end
        end
    end

    // Next-state logic; start is only honoured when no generation is running.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_last_idx = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = PLACE;
                end
            end
            PLACE: begin
                if (w_placed_nxt == MC7)
                    w_next = COUNT;
            end
            COUNT: begin
                if (r_idx == LAST7) begin
                    w_last_idx = 1'b1;
                    w_next     = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Field datapath: clear on accepted start, drop mines, then fill counts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bomb   <= '0;
            r_counts <= '0;
            r_placed <= '0;
            r_idx    <= '0;
            r_safe   <= '0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_safe   <= i_safe_idx;
                        r_bomb   <= '0;
                        r_counts <= '0;
                        r_placed <= '0;
                        r_idx    <= '0;
                        r_valid  <= 1'b0;
                    end
                end
                PLACE: begin
                    if (w_do_place) begin
                        r_bomb[w_cand] <= 1'b1;
                        r_placed       <= w_placed_nxt;
                    end
                end
                COUNT: begin
                    r_counts[r_idx] <= r_bomb[r_idx] ? CNT_BOMB : w_nsum;
                    r_idx           <= r_idx + 7'd1;
                    if (w_last_idx) begin
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state == PLACE) || (r_state == COUNT);
    assign o_done      = r_done;
    assign o_valid     = r_valid;
    assign o_bomb_grid = r_bomb;
    assign o_counts    = r_counts;

endmodule

// File: tb/tb_mine_field_gen.sv
// Bench for mine_field_gen: table of seeds/first clicks, each field checked
// against an LFSR + placement model and a neighbour-count reference, plus
// hand-written sequences for determinism, start spam, reset mid-COUNT and a
// MINE_COUNT=0 instance.
module tb_mine_field_gen;

    localparam int G  = 9;
    localparam int N  = 81;
    localparam int MC = 10;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [6:0]     safe_idx = '0;
    logic           seed_load = 1'b0;
    logic [15:0]    seed = '0;

    logic           busy, done, valid;
    logic [N-1:0]   grid;
    logic [4*N-1:0] counts;
    logic           busy0, done0, valid0;
    logic [N-1:0]   grid0;
    logic [4*N-1:0] counts0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mine_field_gen #(.GRID_SIZE(G), .MINE_COUNT(MC)) dut (
        .clock(clock), .reset(reset), .i_start(start), .i_safe_idx(safe_idx),
        .i_seed_load(seed_load), .i_seed(seed), .o_busy(busy), .o_done(done),
        .o_valid(valid), .o_bomb_grid(grid), .o_counts(counts));

    mine_field_gen #(.GRID_SIZE(G), .MINE_COUNT(0)) dut0 (
        .clock(clock), .reset(reset), .i_start(start), .i_safe_idx(safe_idx),
        .i_seed_load(seed_load), .i_seed(seed), .o_busy(busy0), .o_done(done0),
        .o_valid(valid0), .o_bomb_grid(grid0), .o_counts(counts0));

    typedef struct {
        logic [15:0] seed;
        logic [6:0]  safe;
        int          dly;
        bit          spam;
        int          exp_pop;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Reference LFSR, tracked alongside the DUT from its own ports.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (!reset)
            m_lfsr <= 16'hACE1;
        else if (seed_load)
            m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else
            m_lfsr <= lstep(m_lfsr);
    end

    function automatic bit excluded(input int cand, input int safe);
        if (safe >= N) return 1'b0;
`ifdef MINE_GEN_SAFE_ZONE_EN
        return (cand / G - safe / G >= -1) && (cand / G - safe / G <= 1) &&
               (cand % G - safe % G >= -1) && (cand % G - safe % G <= 1);
`else
        return cand == safe;
`endif
    endfunction

    function automatic void model_place(input logic [15:0] l0, input int safe, input int mc,
                                        output logic [N-1:0] g, output int cycles);
        logic [15:0] l;
        int placed;
        int cand;
        l = l0; placed = 0; g = '0; cycles = 0;
        while (1) begin
            cycles++;
            cand = int'(l[6:0]);
            if (placed < mc && cand < N && !g[cand] && !excluded(cand, safe)) begin
                g[cand] = 1'b1;
                placed++;
            end
            if (placed == mc || cycles > 50000) break;
            l = lstep(l);
        end
    endfunction

    function automatic logic [4*N-1:0] ref_counts(input logic [N-1:0] g);
        logic [4*N-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            int s;
            s = 0;
            for (int r = i / G - 1; r <= i / G + 1; r++)
                for (int c = i % G - 1; c <= i % G + 1; c++)
                    if (r >= 0 && r < G && c >= 0 && c < G && (r * G + c) != i && g[r * G + c])
                        s++;
            res[4*i +: 4] = g[i] ? 4'hF : 4'(s);
        end
        return res;
    endfunction

    task automatic run_gen(input logic [15:0] s, input logic [6:0] sf, input int dly,
                           input bit spam, input int exp_pop, input bit check0,
                           output logic [N-1:0] eg);
        int pc, n, n0, ndone;
        logic [3:0] e0, e8;
        @(negedge clock); seed_load = 1'b1; seed = s;
        @(negedge clock); seed_load = 1'b0;
        repeat (dly) @(negedge clock);
        start = 1'b1; safe_idx = sf;
        @(negedge clock); start = 1'b0;
        model_place(m_lfsr, int'(sf), MC, eg, pc);
        chk("start_valid_drop", 512'(valid), 512'(0));
        chk("start_busy", 512'(busy), 512'(1));
        n = 0; n0 = -1;
        while (n < 2000 && !done) begin
            start = spam && (n < pc + 60) && (n % 2 == 0);
            @(negedge clock);
            n++;
            if (check0 && done0 && n0 < 0) n0 = n;
        end
        start = 1'b0;
        chk("done_latency", 512'(n), 512'(pc + 81));
        chk("grid_model", 512'(grid), 512'(eg));
        chk("mine_popcount", 512'($countones(grid)), 512'(exp_pop));
        if (int'(sf) < N) chk("safe_bit_clear", 512'(grid[sf]), 512'(0));
        chk("counts_ref", 512'(counts), 512'(ref_counts(eg)));
        e0 = eg[0] ? 4'hF : 4'(int'(eg[1]) + int'(eg[9]) + int'(eg[10]));
        e8 = eg[8] ? 4'hF : 4'(int'(eg[7]) + int'(eg[16]) + int'(eg[17]));
        chk("corner0", 512'(counts[3:0]), 512'(e0));
        chk("cell8_nowrap", 512'(counts[35:32]), 512'(e8));
`ifdef MINE_GEN_SAFE_ZONE_EN
        if (int'(sf) < N) chk("safe_zero", 512'(counts[4*sf +: 4]), 512'(0));
`endif
        ndone = 0;
        repeat (4) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("done_width", 512'(ndone), 512'(0));
        chk("valid_hold", 512'(valid), 512'(1));
        chk("busy_done", 512'(busy), 512'(0));
        chk("grid_frozen", 512'(grid), 512'(eg));
        if (check0) begin
            chk("mc0_latency", 512'(n0), 512'(82));
            chk("mc0_grid", 512'(grid0), 512'(0));
            chk("mc0_counts", 512'(counts0), 512'(0));
            chk("mc0_valid", 512'(valid0), 512'(1));
        end
    endtask

    initial begin
        logic [N-1:0] eg, ga, gb;
        int pc;

        vecs[0] = '{16'h0000, 7'd40,  3, 1'b0, 10};
        vecs[1] = '{16'h1234, 7'd0,   1, 1'b0, 10};
        vecs[2] = '{16'hBEEF, 7'd80,  5, 1'b1, 10};
        vecs[3] = '{16'h0001, 7'd8,   2, 1'b0, 10};
        vecs[4] = '{16'h7F7F, 7'd127, 0, 1'b0, 10};
        vecs[5] = '{16'hC0DE, 7'd9,   4, 1'b1, 10};

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_lfsr", 512'(dut.w_lfsr), 512'(16'hACE1));
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_busy", 512'(busy), 512'(0));
        chk("idle_valid", 512'(valid), 512'(0));
        chk("idle_done", 512'(done), 512'(0));
        chk("idle_grid", 512'(grid), 512'(0));
        chk("idle_counts", 512'(counts), 512'(0));

        // Table of fields; the first also exercises the MINE_COUNT=0 build.
        for (int i = 0; i < 6; i++)
            run_gen(vecs[i].seed, vecs[i].safe, vecs[i].dly, vecs[i].spam,
                    vecs[i].exp_pop, (i == 0), eg);

        // Same seed and same start timing give the same field.
        run_gen(16'h5A5A, 7'd20, 2, 1'b0, MC, 1'b0, eg);
        ga = grid;
        run_gen(16'h5A5A, 7'd20, 2, 1'b0, MC, 1'b0, eg);
        gb = grid;
        chk("repeat_grid", 512'(gb), 512'(ga));

        // Reset in the middle of COUNT discards everything.
        @(negedge clock); seed_load = 1'b1; seed = 16'h3333;
        @(negedge clock); seed_load = 1'b0;
        start = 1'b1; safe_idx = 7'd44;
        @(negedge clock); start = 1'b0;
        model_place(m_lfsr, 44, MC, eg, pc);
        repeat (pc + 20) @(negedge clock);
        chk("midcount_busy", 512'(busy), 512'(1));
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_busy", 512'(busy), 512'(0));
        chk("rstmid_valid", 512'(valid), 512'(0));
        chk("rstmid_done", 512'(done), 512'(0));
        chk("rstmid_grid", 512'(grid), 512'(0));
        chk("rstmid_counts", 512'(counts), 512'(0));
        chk("rstmid_lfsr", 512'(dut.w_lfsr), 512'(16'hACE1));
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("after_rst_idle", 512'(busy), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
